pipeline_ctrl: RTL

//   Hazard and sequencing controller for the 5-stage RV32I pipeline. Generates
//   E-stage operand forwarding selects, load-use stalls, and branch flushes.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/pipeline_ctrl_forward_unit.sv | 23 ++
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the RV32I hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int ADW = 5;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} pipe_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // x0 is hardwired to zero, so a write to it never produces a dependency.
  function automatic logic reg_hit(input logic we, input logic [ADW-1:0] rd,
                                   input logic [ADW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Operand forwarding select for one E-stage source register.
// Combinational; the younger M-stage result wins over W on a double match.
module forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [ADW-1:0] rs,
  input  logic [ADW-1:0] rdM,
  input  logic           regwriteM,
  input  logic [ADW-1:0] rdW,
  input  logic           regwriteW,
  output fwd_sel_t       fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_hit(regwriteM, rdM, rs)) begin
      fwd = FWD_MEM;
    end else if (reg_hit(regwriteW, rdW, rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, branch flush, and a
// whole-pipe freeze while data memory is busy, with a timeout into a sticky ERR.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADW-1:0]   rs1D,
  input  logic [ADW-1:0]   rs2D,
  input  logic [ADW-1:0]   rs1E,
  input  logic [ADW-1:0]   rs2E,
  input  logic [ADW-1:0]   rdE,
  input  logic             regwriteE,
  input  logic             resultsrcE,
  input  logic             pc_srcE,
  input  logic [ADW-1:0]   rdM,
  input  logic             regwriteM,
  input  logic             resultsrcM,
  input  logic             memwriteM,
  input  logic [ADW-1:0]   rdW,
  input  logic             regwriteW,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output fwd_sel_t         fwdAE,
  output fwd_sel_t         fwdBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  pipe_state_t       state, state_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  fwd_sel_t          fwd_a, fwd_b;
  logic              mem_acc, mem_stall, load_use;

  forward_unit u_fwd_a (
    .rs        (rs1E),
    .rdM       (rdM),
    .regwriteM (regwriteM),
    .rdW       (rdW),
    .regwriteW (regwriteW),
    .fwd       (fwd_a)
  );

  forward_unit u_fwd_b (
    .rs        (rs2E),
    .rdM       (rdM),
    .regwriteM (regwriteM),
    .rdW       (rdW),
    .regwriteW (regwriteW),
    .fwd       (fwd_b)
  );

  assign fwdAE = rst ? FWD_RF : fwd_a;
  assign fwdBE = rst ? FWD_RF : fwd_b;

  assign mem_acc   = resultsrcM | memwriteM;
  assign dmem_req  = mem_acc & (state != ERR) & ~rst;
  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = resultsrcE &
                     (reg_hit(regwriteE, rdE, rs1D) | reg_hit(regwriteE, rdE, rs2D));
  assign mem_err   = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (stallF && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    stallM  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_n = MEM_WAIT;
          wcnt_n  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_n = RUN;
          wcnt_n  = '0;
        end else if (wcnt == WCNT_LAST) begin
          state_n = ERR;
        end else begin
          wcnt_n = wcnt + WCNT_W'(1);
        end
      end
      ERR:     state_n = ERR;
      default: state_n = RUN;
    endcase

    // A branch under a memory freeze only freezes; the held E instruction
    // re-asserts pc_srcE once memory releases, so the flush is not lost.
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if ((state == ERR) || mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (pc_srcE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

endmodule
